// File: rtl/rotator_pkg.sv
// -----------------------------------------------------------------------------
// rotator_pkg
// Shared definitions for the rotator / rotator_aligner pair on the data path.
//   - state_e       : aligner FSM states (IDLE, SEARCH, DONE)
//   - DEF_WIDTH     : default word width (100 bits)
//   - DEF_MARK_W    : marker field width (8 bits)
//   - DEF_MARKER    : marker value carried in the top MARK_W bits of an
//                     aligned word
//   - ROT_EN_*      : 2-bit rotate-enable encodings, so the transmit-side
//                     rotator and this aligner agree on direction
// -----------------------------------------------------------------------------
package rotator_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } state_e;

   localparam int           DEF_WIDTH  = 100;
   localparam int           DEF_MARK_W = 8;
   localparam logic [7:0]   DEF_MARKER = 8'hA5;

   localparam logic [1:0]   ROT_EN_HOLD  = 2'b00;
   localparam logic [1:0]   ROT_EN_LEFT  = 2'b01;
   localparam logic [1:0]   ROT_EN_RIGHT = 2'b10;

endpackage : rotator_pkg

// File: rtl/rotator_aligner.sv
// -----------------------------------------------------------------------------
// rotator_aligner
// Receive-side partner of the left/right rotator. A word arrives rotated left
// by an unknown amount k. The aligner rotates it right one bit per cycle until
// the marker sits in the top MARK_W bits, then reports the aligned word and k.
// If no rotation exposes the marker, it returns the raw word with out_err set.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   in_valid   in   in_data valid
//   in_ready   out  aligner can accept a word (only while idle)
//   in_data    in   rotated word [WIDTH]
//   out_valid  out  result valid, held until out_ready
//   out_ready  in   downstream accepts result
//   out_data   out  aligned word, or raw word on error [WIDTH]
//   out_offset out  recovered left-rotation amount, 0 on error [CNT_W]
//   out_err    out  marker not found at any rotation
// -----------------------------------------------------------------------------
module rotator_aligner
   import rotator_pkg::*;
#(
   parameter int                WIDTH  = DEF_WIDTH,
   parameter int                MARK_W = DEF_MARK_W,
   parameter logic [MARK_W-1:0] MARKER = DEF_MARKER,
   parameter int                CNT_W  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] out_offset,
   output logic             out_err
);

   // Last rotation tried before declaring the word marker-less.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e             state_q,      state_d;
   logic [WIDTH-1:0]   work_q,       work_d;
   logic [WIDTH-1:0]   raw_q,        raw_d;
   logic [CNT_W-1:0]   cnt_q,        cnt_d;
   logic [WIDTH-1:0]   out_data_q,   out_data_d;
   logic [CNT_W-1:0]   out_offset_q, out_offset_d;
   logic               out_err_q,    out_err_d;
   logic               out_valid_q,  out_valid_d;
   logic               in_ready_q,   in_ready_d;
   logic               marker_hit;

   // Next-state and datapath decode for the search FSM.
   always_comb begin
      state_d      = state_q;
      work_d       = work_q;
      raw_d        = raw_q;
      cnt_d        = cnt_q;
      out_data_d   = out_data_q;
      out_offset_d = out_offset_q;
      out_err_d    = out_err_q;
      marker_hit   = (work_q[WIDTH-1 -: MARK_W] == MARKER);

      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               work_d  = in_data;
               raw_d   = in_data;
               cnt_d   = '0;
               state_d = SEARCH;
            end else begin
               state_d = IDLE;
            end
         end

         SEARCH: begin
            if (marker_hit) begin
               // cnt right-rotations undid exactly cnt left-rotations.
               out_data_d   = work_q;
               out_offset_d = cnt_q;
               out_err_d    = 1'b0;
               state_d      = DONE;
            end else if (cnt_q == CNT_LAST) begin
               out_data_d   = raw_q;
               out_offset_d = '0;
               out_err_d    = 1'b1;
               state_d      = DONE;
            end else begin
               work_d  = {work_q[0], work_q[WIDTH-1:1]};
               cnt_d   = cnt_q + CNT_ONE;
               state_d = SEARCH;
            end
         end

         DONE: begin
            // Result held stable; a new word is accepted only from IDLE,
            // so never in the same cycle as this handshake.
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Handshake outputs are registered as a decode of the next state.
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
   end

   // State, working registers and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         work_q       <= '0;
         raw_q        <= '0;
         cnt_q        <= '0;
         out_data_q   <= '0;
         out_offset_q <= '0;
         out_err_q    <= 1'b0;
         out_valid_q  <= 1'b0;
         in_ready_q   <= 1'b1;
      end else begin
         state_q      <= state_d;
         work_q       <= work_d;
         raw_q        <= raw_d;
         cnt_q        <= cnt_d;
         out_data_q   <= out_data_d;
         out_offset_q <= out_offset_d;
         out_err_q    <= out_err_d;
         out_valid_q  <= out_valid_d;
         in_ready_q   <= in_ready_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_offset = out_offset_q;
   assign out_err    = out_err_q;

endmodule : rotator_aligner
